mem_load_unit: RTL
==================

Name: mem_load_unit

Overview:
- Load-side counterpart of the store controller: issues a word-aligned read to data memory, waits for the returned word, then extracts, aligns and sign/zero-extends the byte, halfword or word selected by funct3.
- Sits between the LSU/EX stage and the data-memory port.
- Uses a valid/ready request handshake and variable-latency memory data return.
- Flags misaligned and illegal-funct3 loads as faults.

Parameters:
- None. Widths are fixed by RV32I: 32-bit address and data.

Ports:
- iCLK  input  1  core clock; all state updates on rising edge
- iRST  input  1  synchronous reset, active-high
- iReqValid  input  1  load request valid
- oReqReady  output  1  unit can accept a request (IDLE only)
- iAddress  input  32  byte address of the load
- iFunct3  input  3  LB=000, LH=001, LW=010, LBU=100, LHU=101
- oMemRead  output  1  memory read strobe, held until data returns
- oMemAddress  output  32  word-aligned read address, {addr[31:2],2'b00}
- oMemByteEnable  output  4  bytes of interest in the current beat
- iMemDataValid  input  1  iMemData valid this cycle
- iMemData  input  32  returned memory word
- oRespValid  output  1  one-cycle pulse: result or fault available
- oData  output  32  extended load result
- oFault  output  1  with oRespValid: misaligned or illegal funct3; oData=0

Behaviour:
- Reset values: all outputs 0, except oReqReady=1. FSM goes to IDLE and captured registers clear.
- FSM states:
  - IDLE: oReqReady=1. On iReqValid, capture iAddress and iFunct3.
    - If the request faults, go to RESP with fault set.
    - Otherwise go to READ0.
  - READ0: oMemRead=1, address/enables for the captured word. Stay until iMemDataValid; on it, latch iMemData and go to RESP (or to READ1, split case only).
  - READ1: only with the optional feature (see below).
  - RESP: oRespValid=1, oData/oFault driven from registers. Always returns to IDLE next cycle; no back-pressure on the response.
- Fault rules:
  - Illegal funct3: 011, 110, 111.
  - LW with addr[1:0]!=0.
  - LH/LHU with addr[0]=1.
  - A faulting request never asserts oMemRead.
- Byte enables:
  - LW: 1111.
  - LH/LHU: offset 00 -> 0011, offset 10 -> 1100.
  - LB/LBU: 0001 << addr[1:0].
- Extraction:
  - byte = word >> 8*addr[1:0].
  - half = word >> 8*addr[1:0] (addr[1] selects the half).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- Latency:
  - Fault: accepted at cycle 0, RESP at cycle 1.
  - Zero-wait memory (iMemDataValid in first READ0 cycle, cycle 1): RESP at cycle 2.
  - Each wait cycle adds 1.
- iMemDataValid outside READ0/READ1 is ignored.
- oMemRead/oMemAddress/oMemByteEnable must stay stable while waiting.
- iRST in any state (including READ0 mid-wait): return to IDLE next cycle with no response. A late iMemDataValid then arrives in IDLE and is ignored.
- oData holds its last value when oRespValid=0; it is 0 after reset.

Optional Feature:
- Macro: MEM_LOAD_MISALIGNED_EN.
- Without it: misaligned loads fault as listed above; READ1 is unreachable and is not synthesized.
- With it: LW with offset!=0 and LH/LHU with offset 11 do not fault; they become two-beat split accesses.
  - READ0 reads word A={addr[31:2],00}.
  - READ1 reads A+4, wrapping 0xFFFFFFFC -> 0x00000000.
  - READ0 enables: 1111 << offset, truncated to 4 bits.
  - READ1 enables: the remaining low bytes.
  - Result = ({hi,lo} >> 8*offset), then extended per funct3.
  - Latency +1 beat, plus wait cycles.
  - Reset during READ1 discards both beats.
- Illegal funct3 still faults with the macro enabled.

Decomposition:
- Shared package / config.v: FUNCT3_LB/LH/LW/LBU/LHU constants (reused by the store controller), plus a load-state enum (IDLE, READ0, READ1, RESP).
- Sub-module: load_extract, purely combinational.
  - Inputs: 64-bit {hi,lo}, offset, funct3.
  - Output: extended 32-bit result.
  - The aligned path drives hi=0.
  - Unit-testable standalone.

Test Plan:
- LB addr 0x1003, memory word 0x80AABBCC, 0 waits -> oMemAddress 0x1000, byte enable 1000, oRespValid at cycle 2, oData 0xFFFFFF80, oFault 0.
- LHU addr 0x2002, word 0xBEEF1234, 5 wait cycles -> oMemRead held for 6 cycles with stable address, oData 0x0000BEEF at cycle 7. Repeat with LH -> 0xFFFFBEEF.
- LW addr 0x3001 without the macro -> no oMemRead, RESP at cycle 1 with oFault=1, oData=0. Repeat with funct3 011 at addr 0x3000 -> same fault.
- With the macro, LW addr 0x3001, words 0x44332211 @0x3000 and 0x88776655 @0x3004 -> enables 1110 then 0001, oData 0x55443322.
- iRST asserted during READ0 wait, then a stale iMemDataValid in IDLE -> no oRespValid. A fresh LW 0x4000 with data 0xDEADBEEF -> 0xDEADBEEF.
- Back-to-back LW requests with iReqValid held high -> oReqReady low from accept through RESP. The second request is accepted the cycle after RESP, and two ordered responses are produced.

Source files
------------

// File: rtl/mem_load_unit_pkg.sv
// Shared load/store constants and load-FSM encodings for mem_load_unit.
// MEM_LOAD_MISALIGNED_EN turns misaligned LW/LH(U) offset 11 into two-beat split reads.
package mem_load_unit_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef logic [1:0] load_state_t;

  localparam load_state_t LD_IDLE  = 2'd0;
  localparam load_state_t LD_READ0 = 2'd1;
  localparam load_state_t LD_READ1 = 2'd2;
  localparam load_state_t LD_RESP  = 2'd3;

  // Bytes touched by the access before shifting by the address offset.
  function automatic logic [3:0] f_size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

`ifdef MEM_LOAD_MISALIGNED_EN
  function automatic logic f_is_split(input logic [2:0] funct3, input logic [1:0] offset);
    return ((funct3 == FUNCT3_LW) && (offset != 2'b00)) ||
           (((funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LHU)) && (offset == 2'b11));
  endfunction
`endif

  function automatic logic f_is_fault(input logic [2:0] funct3, input logic [1:0] offset);
    logic illegal;
    logic misaligned;
    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    case (funct3)
      FUNCT3_LW:             misaligned = (offset != 2'b00);
      FUNCT3_LH, FUNCT3_LHU: misaligned = offset[0];
      default:               misaligned = 1'b0;
    endcase
`ifdef MEM_LOAD_MISALIGNED_EN
    return illegal || (misaligned && !f_is_split(funct3, offset));
`else
    return illegal || misaligned;
`endif
  endfunction

endpackage

// File: rtl/mem_load_unit_load_extract.sv
// Combinational load alignment: shifts {hi,lo} by the byte offset and
// sign/zero-extends the selected byte, halfword or word.
module load_extract
  import mem_load_unit_pkg::*;
(
  input  logic [63:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [31:0] w_shifted;

  assign w_shifted = 32'(i_word >> {i_offset, 3'b000});

  always_comb begin
    o_result = 32'd0;
    case (i_funct3)
      FUNCT3_LB:  o_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
      FUNCT3_LH:  o_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
      FUNCT3_LW:  o_result = w_shifted;
      FUNCT3_LBU: o_result = {24'd0, w_shifted[7:0]};
      FUNCT3_LHU: o_result = {16'd0, w_shifted[15:0]};
      default:    o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Load unit: word-aligned memory read, then extract/extend per funct3.
// MEM_LOAD_MISALIGNED_EN enables two-beat split reads (READ1) for misaligned loads.
//
// state | meaning
// IDLE  | ready for a request; faulting requests go straight to RESP
// READ0 | read strobe on the first (or only) word, wait for data
// READ1 | read strobe on the following word (split accesses only)
// RESP  | one-cycle response pulse, result/fault from registers
module mem_load_unit
  import mem_load_unit_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic [31:0] iAddress,
  input  logic [2:0]  iFunct3,
  output logic        oMemRead,
  output logic [31:0] oMemAddress,
  output logic [3:0]  oMemByteEnable,
  input  logic        iMemDataValid,
  input  logic [31:0] iMemData,
  output logic        oRespValid,
  output logic [31:0] oData,
  output logic        oFault
);

  load_state_t r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_data;
  logic        r_fault;

  logic [63:0] w_ext_word;
  logic [31:0] w_ext_result;
  logic [7:0]  w_be8;
  logic [31:0] w_word_addr;

`ifdef MEM_LOAD_MISALIGNED_EN
  logic [31:0] r_lo;
  assign w_ext_word = (r_state == LD_READ1) ? {iMemData, r_lo} : {32'd0, iMemData};
`else
  assign w_ext_word = {32'd0, iMemData};
`endif

  load_extract u_load_extract (
    .i_word   (w_ext_word),
    .i_offset (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_result (w_ext_result)
  );

  // Low nibble enables the first word, high nibble the spill into the next.
  assign w_be8       = {4'b0000, f_size_mask(r_funct3)} << r_addr[1:0];
  assign w_word_addr = {r_addr[31:2], 2'b00};

  always_comb begin
    oMemRead       = 1'b0;
    oMemAddress    = 32'd0;
    oMemByteEnable = 4'd0;
    case (r_state)
      LD_READ0: begin
        oMemRead       = 1'b1;
        oMemAddress    = w_word_addr;
        oMemByteEnable = w_be8[3:0];
      end
`ifdef MEM_LOAD_MISALIGNED_EN
      LD_READ1: begin
        oMemRead       = 1'b1;
        oMemAddress    = w_word_addr + 32'd4;
        oMemByteEnable = w_be8[7:4];
      end
`endif
      default: ;
    endcase
  end

  assign oReqReady  = (r_state == LD_IDLE);
  assign oRespValid = (r_state == LD_RESP);
  assign oFault     = (r_state == LD_RESP) && r_fault;
  assign oData      = r_data;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state  <= LD_IDLE;
      r_addr   <= 32'd0;
      r_funct3 <= 3'd0;
      r_data   <= 32'd0;
      r_fault  <= 1'b0;
`ifdef MEM_LOAD_MISALIGNED_EN
      r_lo     <= 32'd0;
`endif
    end else begin
      case (r_state)
        LD_IDLE: begin
          if (iReqValid) begin
            r_addr   <= iAddress;
            r_funct3 <= iFunct3;
            if (f_is_fault(iFunct3, iAddress[1:0])) begin
              r_fault <= 1'b1;
              r_data  <= 32'd0;
              r_state <= LD_RESP;
            end else begin
              r_fault <= 1'b0;
              r_state <= LD_READ0;
            end
          end
        end
        LD_READ0: begin
          if (iMemDataValid) begin
`ifdef MEM_LOAD_MISALIGNED_EN
            if (f_is_split(r_funct3, r_addr[1:0])) begin
              r_lo    <= iMemData;
              r_state <= LD_READ1;
            end else begin
              r_data  <= w_ext_result;
              r_state <= LD_RESP;
            end
`else
            r_data  <= w_ext_result;
            r_state <= LD_RESP;
`endif
          end
        end
`ifdef MEM_LOAD_MISALIGNED_EN
        LD_READ1: begin
          if (iMemDataValid) begin
            r_data  <= w_ext_result;
            r_state <= LD_RESP;
          end
        end
`endif
        LD_RESP: r_state <= LD_IDLE;
        default: r_state <= LD_IDLE;
      endcase
    end
  end

endmodule
